// File: rtl/simpleuart_tx_arb.sv
// Round-robin arbiter sharing one simpleuart transmitter among NREQ byte producers.
// A grant is held until the owner sends a byte marked last; define SIMPLEUART_TX_ARB_TIMEOUT_EN to revoke idle locks.
module simpleuart_tx_arb #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  input  logic              uart_enabled,
  output logic              reg_dat_we,
  output logic [31:0]       reg_dat_di,
  input  logic              reg_dat_wait,
  output logic [NREQ-1:0]   grant,
  output logic              busy
);

  localparam int IW = (NREQ > 2) ? 2 : 1;

  if (NREQ < 2 || NREQ > 4 || TIMEOUT < 1) begin : g_bad_param
    $error("simpleuart_tx_arb: NREQ must be 2..4 and TIMEOUT at least 1");
  end

  typedef enum logic [1:0] {IDLE, SEND, LOCK} state_t;

  state_t          state;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   rr;
  logic [7:0]      hbyte;
  logic            hlast;

  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   sel_idx;
  logic [IW-1:0]   owner_nxt;
  logic [IW+2:0]   sel_bit;
  logic            accept;

  // Search rr, rr+1, ... modulo NREQ; walking downwards lets the lowest offset win.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      logic [IW-1:0] idx;
      idx = IW'((int'(rr) + k) % NREQ);
      if (req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (uart_enabled) begin
      if (state == IDLE && win_found) req_ready[win_idx] = 1'b1;
      if (state == LOCK)              req_ready[owner]   = req_valid[owner];
    end
  end

  assign sel_idx    = (state == IDLE) ? win_idx : owner;
  assign sel_bit    = {sel_idx, 3'b000};
  assign accept     = |(req_ready & req_valid);
  assign owner_nxt  = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
  assign reg_dat_di = {24'h0, hbyte};

`ifdef SIMPLEUART_TX_ARB_TIMEOUT_EN
  logic [15:0] to_cnt;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state      <= IDLE;
      owner      <= '0;
      rr         <= '0;
      hbyte      <= '0;
      hlast      <= 1'b0;
      reg_dat_we <= 1'b0;
      grant      <= '0;
      busy       <= 1'b0;
`ifdef SIMPLEUART_TX_ARB_TIMEOUT_EN
      to_cnt     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            owner      <= win_idx;
            hbyte      <= req_data[sel_bit +: 8];
            hlast      <= req_last[win_idx];
            reg_dat_we <= 1'b1;
            grant      <= {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
            busy       <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          // A captured byte is always delivered, whatever uart_enabled does meanwhile.
          if (!reg_dat_wait) begin
            reg_dat_we <= 1'b0;
            hbyte      <= '0;
`ifdef SIMPLEUART_TX_ARB_TIMEOUT_EN
            to_cnt     <= '0;
`endif
            if (hlast) begin
              rr    <= owner_nxt;
              grant <= '0;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              state <= LOCK;
            end
          end
        end
        LOCK: begin
          if (accept) begin
            hbyte      <= req_data[sel_bit +: 8];
            hlast      <= req_last[owner];
            reg_dat_we <= 1'b1;
            state      <= SEND;
`ifdef SIMPLEUART_TX_ARB_TIMEOUT_EN
            to_cnt     <= '0;
          end else if (!req_valid[owner]) begin
            // A silent owner forfeits the lock; its message counts as ended.
            if (to_cnt == 16'(TIMEOUT - 1)) begin
              to_cnt <= '0;
              rr     <= owner_nxt;
              grant  <= '0;
              busy   <= 1'b0;
              state  <= IDLE;
            end else begin
              to_cnt <= to_cnt + 16'd1;
            end
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
